// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with per-register rename status.
// On issue it returns either the committed value of each source or the ROB tag
// that will produce it, then marks rd as renamed to the new tag. Commits write
// the value and release the rename only when the committing tag still owns rd.
// A commit that matches an outstanding rename is forwarded to a same-cycle read.
module rename_regfile #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int TAG_W    = 4,
  parameter int SIDE_W   = 96,
  localparam int RA_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              is_valid,
  input  logic [RA_W-1:0]   is_rs1,
  input  logic [RA_W-1:0]   is_rs2,
  input  logic              is_rd_en,
  input  logic [RA_W-1:0]   is_rd,
  input  logic [TAG_W-1:0]  is_tag,
  input  logic [SIDE_W-1:0] is_side,
  input  logic              cm_valid,
  input  logic [RA_W-1:0]   cm_rd,
  input  logic [TAG_W-1:0]  cm_tag,
  input  logic [XLEN-1:0]   cm_data,
  output logic              out_valid,
  output logic              out_rs1_busy,
  output logic [TAG_W-1:0]  out_rs1_tag,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic              out_rs2_busy,
  output logic [TAG_W-1:0]  out_rs2_tag,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [SIDE_W-1:0] out_side
);

  localparam int LK_W = 1 + TAG_W + XLEN;

  // Per-register architectural state.
  logic [XLEN-1:0]  val_q  [NUM_REGS];
  logic [XLEN-1:0]  val_d  [NUM_REGS];
  logic             busy_q [NUM_REGS];
  logic             busy_d [NUM_REGS];
  logic [TAG_W-1:0] tag_q  [NUM_REGS];
  logic [TAG_W-1:0] tag_d  [NUM_REGS];

  // Registered operand bundle.
  logic              out_valid_q,    out_valid_d;
  logic              out_rs1_busy_q, out_rs1_busy_d;
  logic [TAG_W-1:0]  out_rs1_tag_q,  out_rs1_tag_d;
  logic [XLEN-1:0]   out_rs1_val_q,  out_rs1_val_d;
  logic              out_rs2_busy_q, out_rs2_busy_d;
  logic [TAG_W-1:0]  out_rs2_tag_q,  out_rs2_tag_d;
  logic [XLEN-1:0]   out_rs2_val_q,  out_rs2_val_d;
  logic [SIDE_W-1:0] out_side_q,     out_side_d;

  logic [LK_W-1:0] lk_rs1_s;
  logic [LK_W-1:0] lk_rs2_s;
  logic            rename_s;
  logic            commit_s;

  // Resolve one source operand against pre-update state, forwarding a
  // same-cycle commit whose tag still owns the register. Packed {busy, tag, val}.
  function automatic logic [LK_W-1:0] lookup(
    input logic [RA_W-1:0]  s,
    input logic             b,
    input logic [TAG_W-1:0] t,
    input logic [XLEN-1:0]  v,
    input logic             c_valid,
    input logic [RA_W-1:0]  c_rd,
    input logic [TAG_W-1:0] c_tag,
    input logic [XLEN-1:0]  c_data
  );
    logic [LK_W-1:0] r;
    if (s == {RA_W{1'b0}}) begin
      r = {1'b0, {TAG_W{1'b0}}, {XLEN{1'b0}}};
    end else if (b && c_valid && (c_rd == s) && (c_tag == t)) begin
      r = {1'b0, {TAG_W{1'b0}}, c_data};
    end else if (b) begin
      r = {1'b1, t, {XLEN{1'b0}}};
    end else begin
      r = {1'b0, {TAG_W{1'b0}}, v};
    end
    return r;
  endfunction

  // Source lookups and qualified rename/commit strobes for this cycle.
  always_comb begin
    lk_rs1_s = lookup(is_rs1, busy_q[is_rs1], tag_q[is_rs1], val_q[is_rs1],
                      cm_valid, cm_rd, cm_tag, cm_data);
    lk_rs2_s = lookup(is_rs2, busy_q[is_rs2], tag_q[is_rs2], val_q[is_rs2],
                      cm_valid, cm_rd, cm_tag, cm_data);
    rename_s = en && !flush && is_valid && is_rd_en && (is_rd != {RA_W{1'b0}});
    commit_s = en && cm_valid && (cm_rd != {RA_W{1'b0}});
  end

  // Next register-file state: flush clears rename status, commit writes value
  // and releases a matching rename, a same-cycle rename takes precedence.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      val_d[i]  = val_q[i];
      busy_d[i] = busy_q[i];
      tag_d[i]  = tag_q[i];
      if (commit_s && (cm_rd == RA_W'(i))) begin
        val_d[i] = cm_data;
      end else begin
        val_d[i] = val_q[i];
      end
      if (flush) begin
        busy_d[i] = 1'b0;
        tag_d[i]  = {TAG_W{1'b0}};
      end else if (commit_s && (cm_rd == RA_W'(i)) && busy_q[i] && (tag_q[i] == cm_tag)) begin
        busy_d[i] = 1'b0;
        tag_d[i]  = {TAG_W{1'b0}};
      end else begin
        busy_d[i] = busy_q[i];
        tag_d[i]  = tag_q[i];
      end
      if (rename_s && (is_rd == RA_W'(i))) begin
        busy_d[i] = 1'b1;
        tag_d[i]  = is_tag;
      end else begin
        busy_d[i] = busy_d[i];
        tag_d[i]  = tag_d[i];
      end
    end
  end

  // Next operand bundle: flush drops the issue, an idle enabled cycle clears
  // only out_valid, a stalled cycle holds everything.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_rs1_busy_d = out_rs1_busy_q;
    out_rs1_tag_d  = out_rs1_tag_q;
    out_rs1_val_d  = out_rs1_val_q;
    out_rs2_busy_d = out_rs2_busy_q;
    out_rs2_tag_d  = out_rs2_tag_q;
    out_rs2_val_d  = out_rs2_val_q;
    out_side_d     = out_side_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (en) begin
      if (is_valid) begin
        out_valid_d = 1'b1;
        {out_rs1_busy_d, out_rs1_tag_d, out_rs1_val_d} = lk_rs1_s;
        {out_rs2_busy_d, out_rs2_tag_d, out_rs2_val_d} = lk_rs2_s;
        out_side_d  = is_side;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Register-file state flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i]  <= {XLEN{1'b0}};
        busy_q[i] <= 1'b0;
        tag_q[i]  <= {TAG_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i]  <= val_d[i];
        busy_q[i] <= busy_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  // Operand bundle flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_rs1_busy_q <= 1'b0;
      out_rs1_tag_q  <= {TAG_W{1'b0}};
      out_rs1_val_q  <= {XLEN{1'b0}};
      out_rs2_busy_q <= 1'b0;
      out_rs2_tag_q  <= {TAG_W{1'b0}};
      out_rs2_val_q  <= {XLEN{1'b0}};
      out_side_q     <= {SIDE_W{1'b0}};
    end else begin
      out_valid_q    <= out_valid_d;
      out_rs1_busy_q <= out_rs1_busy_d;
      out_rs1_tag_q  <= out_rs1_tag_d;
      out_rs1_val_q  <= out_rs1_val_d;
      out_rs2_busy_q <= out_rs2_busy_d;
      out_rs2_tag_q  <= out_rs2_tag_d;
      out_rs2_val_q  <= out_rs2_val_d;
      out_side_q     <= out_side_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rs1_busy = out_rs1_busy_q;
  assign out_rs1_tag  = out_rs1_tag_q;
  assign out_rs1_val  = out_rs1_val_q;
  assign out_rs2_busy = out_rs2_busy_q;
  assign out_rs2_tag  = out_rs2_tag_q;
  assign out_rs2_val  = out_rs2_val_q;
  assign out_side     = out_side_q;

endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed scenarios followed by a randomized run, all
// checked against a behavioural model of the register file and rename table.
module tb_rename_regfile;

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;
  localparam int TAG_W    = 4;
  localparam int SIDE_W   = 96;
  localparam int RA_W     = 5;

  logic              clk = 1'b0;
  logic              rst, en, flush;
  logic              is_valid, is_rd_en, cm_valid;
  logic [RA_W-1:0]   is_rs1, is_rs2, is_rd, cm_rd;
  logic [TAG_W-1:0]  is_tag, cm_tag;
  logic [SIDE_W-1:0] is_side;
  logic [XLEN-1:0]   cm_data;
  logic              out_valid, out_rs1_busy, out_rs2_busy;
  logic [TAG_W-1:0]  out_rs1_tag, out_rs2_tag;
  logic [XLEN-1:0]   out_rs1_val, out_rs2_val;
  logic [SIDE_W-1:0] out_side;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: committed values, pending flags, owning tags.
  logic [XLEN-1:0]   m_val  [NUM_REGS];
  logic              m_busy [NUM_REGS];
  logic [TAG_W-1:0]  m_tag  [NUM_REGS];
  logic              e_valid;
  logic              e_b1, e_b2;
  logic [TAG_W-1:0]  e_t1, e_t2;
  logic [XLEN-1:0]   e_v1, e_v2;
  logic [SIDE_W-1:0] e_side;

  rename_regfile #(.NUM_REGS(NUM_REGS), .XLEN(XLEN), .TAG_W(TAG_W), .SIDE_W(SIDE_W)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .is_valid(is_valid), .is_rs1(is_rs1), .is_rs2(is_rs2), .is_rd_en(is_rd_en),
    .is_rd(is_rd), .is_tag(is_tag), .is_side(is_side),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
    .out_valid(out_valid),
    .out_rs1_busy(out_rs1_busy), .out_rs1_tag(out_rs1_tag), .out_rs1_val(out_rs1_val),
    .out_rs2_busy(out_rs2_busy), .out_rs2_tag(out_rs2_tag), .out_rs2_val(out_rs2_val),
    .out_side(out_side)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; en = 1'b1; flush = 1'b0;
    is_valid = 1'b0; is_rs1 = '0; is_rs2 = '0; is_rd_en = 1'b0; is_rd = '0;
    is_tag = '0; is_side = '0;
    cm_valid = 1'b0; cm_rd = '0; cm_tag = '0; cm_data = '0;
  endtask

  // What a read of register s should return this cycle.
  task automatic model_read(input logic [RA_W-1:0] s, output logic b,
                            output logic [TAG_W-1:0] t, output logic [XLEN-1:0] v);
    b = 1'b0; t = '0; v = '0;
    if (s == 0) begin
      b = 1'b0;
    end else if (m_busy[s] && cm_valid && cm_rd == s && cm_tag == m_tag[s]) begin
      v = cm_data;
    end else if (m_busy[s]) begin
      b = 1'b1; t = m_tag[s];
    end else begin
      v = m_val[s];
    end
  endtask

  // Advance the model one clock using the inputs currently driven.
  task automatic model_step();
    logic ren;
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
      e_valid = 0; e_b1 = 0; e_b2 = 0; e_t1 = '0; e_t2 = '0; e_v1 = '0; e_v2 = '0; e_side = '0;
    end else if (flush) begin
      if (en && cm_valid && cm_rd != 0) m_val[cm_rd] = cm_data;
      for (int i = 0; i < NUM_REGS; i++) begin
        m_busy[i] = 1'b0; m_tag[i] = '0;
      end
      e_valid = 0;
    end else if (en) begin
      if (is_valid) begin
        model_read(is_rs1, e_b1, e_t1, e_v1);
        model_read(is_rs2, e_b2, e_t2, e_v2);
        e_side = is_side;
      end
      e_valid = is_valid;
      ren = is_valid && is_rd_en && is_rd != 0;
      if (cm_valid && cm_rd != 0) begin
        m_val[cm_rd] = cm_data;
        if (m_busy[cm_rd] && m_tag[cm_rd] == cm_tag && !(ren && is_rd == cm_rd))
          m_busy[cm_rd] = 1'b0;
      end
      if (ren) begin
        m_busy[is_rd] = 1'b1; m_tag[is_rd] = is_tag;
      end
    end
  endtask

  // One clock: update the model, then compare every output after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("out_valid", 128'(out_valid), 128'(e_valid));
    chk("rs1", {out_rs1_busy, out_rs1_tag, out_rs1_val}, {e_b1, e_t1, e_v1});
    chk("rs2", {out_rs2_busy, out_rs2_tag, out_rs2_val}, {e_b2, e_t2, e_v2});
    chk("side", 128'(out_side), 128'(e_side));
    idle();
  endtask

  task automatic issue(input int rs1, input int rs2, input bit rd_en, input int rd, input int tag);
    is_valid = 1'b1; is_rs1 = RA_W'(rs1); is_rs2 = RA_W'(rs2);
    is_rd_en = rd_en; is_rd = RA_W'(rd); is_tag = TAG_W'(tag);
    is_side = {$urandom, $urandom, $urandom};
  endtask

  task automatic commit(input int rd, input int tag, input int data);
    cm_valid = 1'b1; cm_rd = RA_W'(rd); cm_tag = TAG_W'(tag); cm_data = XLEN'(data);
  endtask

  initial begin
    logic [XLEN-1:0] hold_v;
    idle();
    // Reset.
    rst = 1'b1; tick(); tick();
    chk("reset_valid", 128'(out_valid), 128'(0));
    // First issue after reset: values zero, nothing pending.
    issue(5, 6, 0, 0, 0); tick();
    chk("first_valid", 128'(out_valid), 128'(1));
    chk("first_rs1", {out_rs1_busy, out_rs1_val}, {1'b0, 32'h0});
    chk("first_rs2", {out_rs2_busy, out_rs2_val}, {1'b0, 32'h0});
    // Commit without prior rename writes the value.
    commit(5, 3, 32'h1234); tick();
    chk("idle_valid", 128'(out_valid), 128'(0));
    issue(5, 0, 0, 0, 0); tick();
    chk("commit_val", {out_rs1_busy, out_rs1_val}, {1'b0, 32'h1234});
    // Rename then read.
    issue(0, 0, 1, 7, 2); tick();
    issue(7, 0, 0, 0, 0); tick();
    chk("renamed", {out_rs1_busy, out_rs1_tag}, {1'b1, 4'd2});
    // Commit-to-issue bypass, busy cleared afterwards.
    commit(7, 2, 32'hAA); issue(7, 0, 0, 0, 0); tick();
    chk("bypass", {out_rs1_busy, out_rs1_tag, out_rs1_val}, {1'b0, 4'd0, 32'hAA});
    issue(7, 7, 0, 0, 0); tick();
    chk("released", {out_rs1_busy, out_rs1_val}, {1'b0, 32'hAA});
    // Stale commit: value written, younger rename stays.
    issue(0, 0, 1, 7, 2); tick();
    issue(0, 0, 1, 7, 4); tick();
    commit(7, 2, 32'h11); tick();
    issue(7, 0, 0, 0, 0); tick();
    chk("stale_commit", {out_rs1_busy, out_rs1_tag}, {1'b1, 4'd4});
    commit(7, 4, 32'h22); tick();
    issue(7, 0, 0, 0, 0); tick();
    chk("late_release", {out_rs1_busy, out_rs1_val}, {1'b0, 32'h22});
    // rs == rd returns the old mapping.
    issue(0, 0, 1, 9, 1); tick();
    issue(9, 0, 1, 9, 5); tick();
    chk("rs_eq_rd", {out_rs1_busy, out_rs1_tag}, {1'b1, 4'd1});
    issue(9, 0, 0, 0, 0); tick();
    chk("new_map", {out_rs1_busy, out_rs1_tag}, {1'b1, 4'd5});
    // x0 is never renamed or written.
    commit(0, 0, 32'h55); issue(0, 0, 1, 0, 6); tick();
    issue(0, 0, 0, 0, 0); tick();
    chk("x0", {out_rs1_busy, out_rs1_tag, out_rs1_val}, {1'b0, 4'd0, 32'h0});
    // Tag 0 is a legal tag; busy marks pending.
    issue(0, 0, 1, 12, 0); tick();
    issue(12, 0, 0, 0, 0); tick();
    chk("tag0_busy", {out_rs1_busy, out_rs1_tag}, {1'b1, 4'd0});
    // Flush with en=0 drops the concurrent issue and clears renames.
    issue(0, 0, 1, 3, 7); tick();
    issue(0, 0, 1, 4, 8); tick();
    flush = 1'b1; en = 1'b0; issue(3, 4, 1, 8, 9); tick();
    chk("flush_valid", 128'(out_valid), 128'(0));
    issue(3, 4, 0, 0, 0); tick();
    chk("flush_clr", {out_rs1_busy, out_rs2_busy}, 2'b00);
    issue(8, 0, 0, 0, 0); tick();
    chk("flush_drop", 128'(out_rs1_busy), 128'(0));
    // Stall: issue pending with en=0 leaves outputs unchanged.
    hold_v = out_rs1_val;
    en = 1'b0; issue(5, 5, 1, 5, 3); tick();
    chk("stall_hold", {out_valid, out_rs1_val}, {1'b1, hold_v});
    issue(5, 0, 0, 0, 0); tick();
    chk("stall_norename", {out_rs1_busy, out_rs1_val}, {1'b0, 32'h1234});
    // Randomized traffic on a narrow register window to force collisions.
    for (int n = 0; n < 1500; n++) begin
      rst   = ($urandom_range(199) == 0);
      flush = ($urandom_range(29) == 0);
      en    = ($urandom_range(9) != 0);
      if ($urandom_range(3) != 0)
        issue($urandom_range(7), $urandom_range(7), 1'($urandom_range(1)),
              $urandom_range(7), $urandom_range(15));
      if ($urandom_range(2) != 0) begin
        cm_valid = 1'b1; cm_rd = RA_W'($urandom_range(7)); cm_data = $urandom;
        cm_tag = ($urandom_range(1) != 0) ? m_tag[cm_rd] : TAG_W'($urandom_range(15));
      end
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
